alien_bomb_ctrl: RTL and testbench

Downward counterpart of the player bullet. Periodically picks a random alien column, finds its lowest living alien, and spawns a bomb beneath it. Bombs fall once per frame, and the block detects collisions with the player, producing a hit pulse and maintaining the lives count. Sits beside the bullet logic and consumes the same alien grid and formation position; outputs go to the VGA renderer and the game FSM.

---
 rtl/invaders_pkg.sv | 30 +++
 rtl/bomb_lfsr.sv | 30 +++
 rtl/alien_bomb_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_alien_bomb_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/invaders_pkg.sv
// Shared Space Invaders geometry, screen limits and the bomb FSM state encoding.
package invaders_pkg;

  localparam int unsigned ALIEN_W       = 30;
  localparam int unsigned ALIEN_H       = 20;
  localparam int unsigned ALIEN_SPACING = 10;
  localparam int unsigned NUM_ROWS      = 5;
  localparam int unsigned NUM_COLS      = 10;
  localparam int unsigned PLAYER_W      = 30;
  localparam int unsigned PLAYER_H      = 20;
  localparam int unsigned SCREEN_H      = 480;
  localparam int unsigned OFFSCREEN_ROW = 500;
  localparam int unsigned START_LIVES   = 3;

  localparam int unsigned ROW_PITCH = ALIEN_H + ALIEN_SPACING;
  localparam int unsigned COL_PITCH = ALIEN_W + ALIEN_SPACING;

  typedef enum logic [1:0] {
    StWait,
    StPick,
    StScan,
    StSpawn
  } bomb_state_e;

  // Folds a 4-bit random value onto a valid column index.
  function automatic logic [3:0] wrap_col(input logic [3:0] c);
    return (c >= 4'(NUM_COLS)) ? c - 4'(NUM_COLS) : c;
  endfunction

endpackage

// File: rtl/bomb_lfsr.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) with reset seed and advance enable.
module bomb_lfsr #(
  parameter logic [7:0] Seed = 8'hA5
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Advance,
  output logic [7:0] Value
);

  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (Advance) begin
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      lfsr_q <= Seed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign Value = lfsr_q;

endmodule

// File: rtl/alien_bomb_ctrl.sv
// Alien bomb spawner, faller and player-collision tracker.
// Define BOMB_INVULN_EN to add a post-hit invulnerability window.
module alien_bomb_ctrl
  import invaders_pkg::*;
#(
  parameter int unsigned NUM_BOMBS     = 4,
  parameter int unsigned BOMB_SPEED    = 4,
  parameter int unsigned FIRE_INTERVAL = 48
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Tick,
  input  logic [49:0]            Aliens_Grid,
  input  logic [8:0]             Aliens_Row,
  input  logic [9:0]             Aliens_Col,
  input  logic [8:0]             Player_Row,
  input  logic [9:0]             Player_Col,
  output logic [NUM_BOMBS*9-1:0] Bomb_Row,
  output logic [NUM_BOMBS*10-1:0] Bomb_Col,
  output logic [NUM_BOMBS-1:0]   Bomb_Active,
  output logic                   Player_Hit,
  output logic [1:0]             Lives,
  output logic                   Player_Dead
);

  localparam int unsigned CntW = $clog2(FIRE_INTERVAL + 1);
  localparam logic [CntW-1:0] CntFire = CntW'(FIRE_INTERVAL - 1);
  localparam logic [CntW-1:0] CntSat  = CntW'(FIRE_INTERVAL);

  bomb_state_e          state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [3:0]           col_q, col_d, tries_q, tries_d;
  logic [2:0]           row_q, row_d;
  logic [NUM_BOMBS-1:0] active_q, active_d, collide, spawn_sel;
  logic [8:0]           brow_q [NUM_BOMBS];
  logic [8:0]           brow_d [NUM_BOMBS];
  logic [9:0]           bcol_q [NUM_BOMBS];
  logic [9:0]           bcol_d [NUM_BOMBS];
  logic                 hit_q, hit_d;
  logic [1:0]           lives_q, lives_d;
  logic [7:0]           lfsr;
  logic [5:0]           grid_idx;
  logic [9:0]           spawn_row, spawn_col;
  logic                 dead, fire, grid_bit, do_spawn, any_hit, guard, taken;
  logic                 unused_lfsr;

  bomb_lfsr #(
    .Seed(8'hA5)
  ) u_lfsr (
    .Clk    (Clk),
    .Reset  (Reset),
    .Advance(1'b1),
    .Value  (lfsr)
  );

  assign unused_lfsr = ^lfsr[7:4];
  assign dead        = (lives_q == 2'd0);
  assign grid_idx    = 6'(row_q) * 6'(NUM_COLS) + 6'(col_q);
  assign grid_bit    = Aliens_Grid[grid_idx];
  assign spawn_row   = 10'(Aliens_Row) + 10'(row_q) * 10'(ROW_PITCH) + 10'(ALIEN_H);
  assign spawn_col   = Aliens_Col + 10'(col_q) * 10'(COL_PITCH) + 10'(ALIEN_W / 2);
  assign do_spawn    = (state_q == StSpawn) && !dead;
  // A Tick missed while busy leaves the counter parked at CntSat until WAIT.
  assign fire        = (state_q == StWait) && ((cnt_q == CntSat) || (Tick && (cnt_q == CntFire)));

`ifdef BOMB_INVULN_EN
  logic [5:0] inv_q, inv_d;

  always_comb begin
    inv_d = inv_q;
    if (any_hit) begin
      inv_d = 6'd60;
    end else if (Tick && (inv_q != 6'd0)) begin
      inv_d = inv_q - 6'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      inv_q <= 6'd0;
    end else begin
      inv_q <= inv_d;
    end
  end

  assign guard = (inv_q == 6'd0);
`else
  assign guard = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    row_d   = row_q;
    tries_d = tries_q;
    if (Tick && (cnt_q != CntSat)) begin
      cnt_d = cnt_q + 1'b1;
    end
    unique case (state_q)
      StWait: begin
        if (fire) begin
          cnt_d = '0;
          if (!dead) begin
            state_d = StPick;
          end
        end
      end
      StPick: begin
        col_d   = wrap_col(lfsr[3:0]);
        row_d   = 3'(NUM_ROWS - 1);
        tries_d = 4'd0;
        state_d = StScan;
      end
      StScan: begin
        if (grid_bit) begin
          state_d = StSpawn;
        end else if (row_q == 3'd0) begin
          col_d   = (col_q == 4'(NUM_COLS - 1)) ? 4'd0 : col_q + 4'd1;
          row_d   = 3'(NUM_ROWS - 1);
          tries_d = tries_q + 4'd1;
          if (tries_q == 4'(NUM_COLS - 1)) begin
            state_d = StWait;
          end
        end else begin
          row_d = row_q - 3'd1;
        end
      end
      StSpawn: begin
        state_d = StWait;
      end
    endcase
  end

  always_comb begin
    collide = '0;
    for (int k = 0; k < NUM_BOMBS; k++) begin
      collide[k] = active_q[k] && guard
          && (10'(brow_q[k]) >= 10'(Player_Row))
          && (10'(brow_q[k]) <= 10'(Player_Row) + 10'(PLAYER_H))
          && (11'(bcol_q[k]) >= 11'(Player_Col))
          && (11'(bcol_q[k]) <= 11'(Player_Col) + 11'(PLAYER_W));
    end
  end

  assign any_hit = (|collide) && !dead;

  always_comb begin
    spawn_sel = '0;
    taken     = 1'b0;
    for (int k = 0; k < NUM_BOMBS; k++) begin
      if (!active_q[k] && !taken) begin
        spawn_sel[k] = 1'b1;
        taken        = 1'b1;
      end
    end
  end

  // Per slot: death clear, then collision, then motion, then spawn into a free slot.
  always_comb begin
    for (int k = 0; k < NUM_BOMBS; k++) begin
      active_d[k] = active_q[k];
      brow_d[k]   = brow_q[k];
      bcol_d[k]   = bcol_q[k];
      if (dead || collide[k]) begin
        active_d[k] = 1'b0;
        brow_d[k]   = 9'(OFFSCREEN_ROW);
      end else if (active_q[k]) begin
        if (Tick) begin
          if (10'(brow_q[k]) + 10'(BOMB_SPEED) >= 10'(SCREEN_H)) begin
            active_d[k] = 1'b0;
            brow_d[k]   = 9'(OFFSCREEN_ROW);
          end else begin
            brow_d[k] = brow_q[k] + 9'(BOMB_SPEED);
          end
        end
      end else if (do_spawn && spawn_sel[k]) begin
        active_d[k] = 1'b1;
        brow_d[k]   = spawn_row[8:0];
        bcol_d[k]   = spawn_col;
      end
    end
  end

  always_comb begin
    hit_d   = any_hit;
    lives_d = lives_q;
    if (any_hit && (lives_q != 2'd0)) begin
      lives_d = lives_q - 2'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= StWait;
      cnt_q    <= '0;
      col_q    <= 4'd0;
      row_q    <= 3'd0;
      tries_q  <= 4'd0;
      active_q <= '0;
      hit_q    <= 1'b0;
      lives_q  <= 2'(START_LIVES);
      for (int k = 0; k < NUM_BOMBS; k++) begin
        brow_q[k] <= 9'(OFFSCREEN_ROW);
        bcol_q[k] <= 10'd0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      col_q    <= col_d;
      row_q    <= row_d;
      tries_q  <= tries_d;
      active_q <= active_d;
      hit_q    <= hit_d;
      lives_q  <= lives_d;
      for (int k = 0; k < NUM_BOMBS; k++) begin
        brow_q[k] <= brow_d[k];
        bcol_q[k] <= bcol_d[k];
      end
    end
  end

  always_comb begin
    Bomb_Row = '0;
    Bomb_Col = '0;
    for (int k = 0; k < NUM_BOMBS; k++) begin
      Bomb_Row[9*k +: 9]   = brow_q[k];
      Bomb_Col[10*k +: 10] = bcol_q[k];
    end
  end

  assign Bomb_Active = active_q;
  assign Player_Hit  = hit_q;
  assign Lives       = lives_q;
  assign Player_Dead = dead;

endmodule

// File: tb/tb_alien_bomb_ctrl.sv
// Directed bench: default instance plus a FIRE_INTERVAL=2 instance for slot-pressure cases.
module tb_alien_bomb_ctrl;

  localparam int FRAME_IDLE = 53;

  logic        Clk = 1'b0;
  logic        Reset, Tick;
  logic [49:0] Aliens_Grid;
  logic [8:0]  Aliens_Row, Player_Row;
  logic [9:0]  Aliens_Col, Player_Col;

  logic [35:0] Bomb_Row, f_bomb_row;
  logic [39:0] Bomb_Col, f_bomb_col;
  logic [3:0]  Bomb_Active, f_active;
  logic        Player_Hit, f_hit, Player_Dead, f_dead;
  logic [1:0]  Lives, f_lives;

  int n_cmp, n_bad, hits, f_hits, s1_col;
  logic col_ok;
  logic [35:0] rows_off;
  logic [49:0] grid_all, grid_b0;

  alien_bomb_ctrl u_dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Tick       (Tick),
    .Aliens_Grid(Aliens_Grid),
    .Aliens_Row (Aliens_Row),
    .Aliens_Col (Aliens_Col),
    .Player_Row (Player_Row),
    .Player_Col (Player_Col),
    .Bomb_Row   (Bomb_Row),
    .Bomb_Col   (Bomb_Col),
    .Bomb_Active(Bomb_Active),
    .Player_Hit (Player_Hit),
    .Lives      (Lives),
    .Player_Dead(Player_Dead)
  );

  alien_bomb_ctrl #(
    .FIRE_INTERVAL(2)
  ) u_fast (
    .Clk        (Clk),
    .Reset      (Reset),
    .Tick       (Tick),
    .Aliens_Grid(Aliens_Grid),
    .Aliens_Row (Aliens_Row),
    .Aliens_Col (Aliens_Col),
    .Player_Row (Player_Row),
    .Player_Col (Player_Col),
    .Bomb_Row   (f_bomb_row),
    .Bomb_Col   (f_bomb_col),
    .Bomb_Active(f_active),
    .Player_Hit (f_hit),
    .Lives      (f_lives),
    .Player_Dead(f_dead)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (Reset) begin
      hits   <= 0;
      f_hits <= 0;
    end else begin
      if (Player_Hit) hits <= hits + 1;
      if (f_hit) f_hits <= f_hits + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic frame(input int n);
    for (int i = 0; i < n; i++) begin
      Tick = 1'b1;
      @(negedge Clk);
      Tick = 1'b0;
      repeat (FRAME_IDLE) @(negedge Clk);
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rows_off = {4{9'd500}};
    grid_all = '1;
    grid_b0  = 50'd1;
    Tick = 1'b0;
    Reset = 1'b1;
    Aliens_Grid = grid_all;
    Aliens_Row = 9'd20;
    Aliens_Col = 10'd40;
    Player_Row = 9'd0;
    Player_Col = 10'd900;
    repeat (3) @(negedge Clk);
    check("rst_active", 64'(Bomb_Active), 64'd0);
    check("rst_row", 64'(Bomb_Row), 64'(rows_off));
    check("rst_col", 64'(Bomb_Col), 64'd0);
    check("rst_hit", 64'(Player_Hit), 64'd0);
    check("rst_lives", 64'(Lives), 64'd3);
    check("rst_dead", 64'(Player_Dead), 64'd0);
    Reset = 1'b0;

    // First spawn from a full grid: bottom row, random column.
    frame(47);
    check("s1_early", 64'(Bomb_Active), 64'd0);
    frame(1);
    check("s1_active", 64'(Bomb_Active), 64'd1);
    check("s1_row", 64'(Bomb_Row[8:0]), 64'd160);
    s1_col = int'(Bomb_Col[9:0]);
    col_ok = (s1_col >= 55) && (s1_col <= 415) && (((s1_col - 55) % 40) == 0);
    check("s1_col", 64'(col_ok), 64'd1);

    // Empty grid gives nothing; lone corner alien is found on the next attempt.
    do_reset();
    Aliens_Grid = '0;
    frame(48);
    check("s2_empty", 64'(Bomb_Active), 64'd0);
    Aliens_Grid = grid_b0;
    Aliens_Row = 9'd100;
    Aliens_Col = 10'd200;
    frame(47);
    check("s2_early", 64'(Bomb_Active), 64'd0);
    frame(1);
    check("s2_active", 64'(Bomb_Active), 64'd1);
    check("s2_row", 64'(Bomb_Row[8:0]), 64'd120);
    check("s2_col", 64'(Bomb_Col[9:0]), 64'd215);

    // Bomb leaving the bottom of the screen.
    do_reset();
    Aliens_Row = 9'd456;
    Aliens_Col = 10'd0;
    frame(48);
    check("s3_active", 64'(Bomb_Active), 64'd1);
    check("s3_row", 64'(Bomb_Row[8:0]), 64'd476);
    check("s3_col", 64'(Bomb_Col[9:0]), 64'd15);
    frame(1);
    check("s3_gone", 64'(Bomb_Active), 64'd0);
    check("s3_offrow", 64'(Bomb_Row), 64'(rows_off));
    check("s3_nohit", 64'(hits), 64'd0);

    // Single hit, then two bombs landing together.
    do_reset();
    Player_Row = 9'd440;
    Player_Col = 10'd100;
    Aliens_Row = 9'd400;
    Aliens_Col = 10'd95;
    frame(48);
    check("s4_spawn", 64'(Bomb_Active), 64'd1);
    check("s4_row", 64'(Bomb_Row[8:0]), 64'd420);
    check("s4_col", 64'(Bomb_Col[9:0]), 64'd110);
    frame(4);
    check("s4_pre_row", 64'(Bomb_Row[8:0]), 64'd436);
    check("s4_pre_hits", 64'(hits), 64'd0);
    frame(1);
    check("s4_hit_once", 64'(hits), 64'd1);
    check("s4_lives2", 64'(Lives), 64'd2);
    check("s4_freed", 64'(Bomb_Active), 64'd0);
    check("s4_freed_row", 64'(Bomb_Row), 64'(rows_off));
    Aliens_Row = 9'd220;
    frame(43);
    check("s4_b1_row", 64'(Bomb_Row[8:0]), 64'd240);
    Aliens_Row = 9'd412;
    frame(48);
    check("s4_pair", 64'(Bomb_Active), 64'd3);
    check("s4_pair_rows", 64'(Bomb_Row[17:0]), 64'({9'd432, 9'd432}));
    frame(1);
    check("s4_pair_pre", 64'(hits), 64'd1);
    frame(1);
    check("s4_pair_hits", 64'(hits), 64'd2);
    check("s4_lives1", 64'(Lives), 64'd1);
    check("s4_pair_freed", 64'(Bomb_Active), 64'd0);
    check("s4_alive", 64'(Player_Dead), 64'd0);

    // All slots busy: the fifth spawn must be dropped.
    do_reset();
    Player_Row = 9'd0;
    Player_Col = 10'd900;
    Aliens_Row = 9'd100;
    Aliens_Col = 10'd0;
    frame(8);
    check("s5_full", 64'(f_active), 64'hF);
    check("s5_rows", 64'(f_bomb_row), 64'({9'd120, 9'd128, 9'd136, 9'd144}));
    frame(2);
    check("s5_still_full", 64'(f_active), 64'hF);
    check("s5_no_overwrite", 64'(f_bomb_row), 64'({9'd128, 9'd136, 9'd144, 9'd152}));

`ifndef BOMB_INVULN_EN
    // Three hits kill the player; everything clears and stays clear.
    do_reset();
    Player_Row = 9'd440;
    Player_Col = 10'd100;
    Aliens_Row = 9'd400;
    Aliens_Col = 10'd95;
    frame(10);
    check("s6_lives1", 64'(f_lives), 64'd1);
    check("s6_hits2", 64'(f_hits), 64'd2);
    frame(1);
    check("s6_lives0", 64'(f_lives), 64'd0);
    check("s6_dead", 64'(f_dead), 64'd1);
    check("s6_cleared", 64'(f_active), 64'd0);
    check("s6_hits3", 64'(f_hits), 64'd3);
    frame(6);
    check("s6_no_spawn", 64'(f_active), 64'd0);
    check("s6_no_more_hits", 64'(f_hits), 64'd3);
    check("s6_rows_off", 64'(f_bomb_row), 64'(rows_off));
`else
    // Invulnerability: later bombs pass through until the window expires.
    do_reset();
    Player_Row = 9'd440;
    Player_Col = 10'd100;
    Aliens_Row = 9'd400;
    Aliens_Col = 10'd95;
    frame(7);
    check("s7_first", 64'(f_hits), 64'd1);
    check("s7_lives2", 64'(f_lives), 64'd2);
    frame(10);
    check("s7_ignored", 64'(f_hits), 64'd1);
    check("s7_lives_kept", 64'(f_lives), 64'd2);
    frame(49);
    check("s7_window_end", 64'(f_hits), 64'd1);
    frame(1);
    check("s7_counts", 64'(f_hits), 64'd2);
    check("s7_lives1", 64'(f_lives), 64'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
